// File: rtl/stitch_pipeline_ctrl.sv
// rtl/stitch_pipeline_ctrl.sv - valid/ready sequencer for a stitched N-stage pipeline
module stitch_pipeline_ctrl #(
  parameter int STAGES = 2,
  parameter int CNT_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [STAGES-1:0]            stage_en,
  output logic [STAGES-1:0]            stage_valid,
  input  logic                         drain_req,
  output logic                         drain_done,
  input  logic                         flush,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [CNT_W-1:0]             txn_count,
  output logic [CNT_W-1:0]             stall_count
);

  localparam int OCC_W = $clog2(STAGES + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [STAGES-1:0]  v_q, v_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [CNT_W-1:0]   txn_q, txn_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [STAGES:0]    rdy;
  logic               accept_en;

  // A stage can load when it is empty or the stage after it is moving.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] | rdy[k+1];
    end
  end

  assign accept_en   = (state_q == ST_RUN);
  assign in_ready    = rdy[0] & accept_en & !flush;
  assign stage_en    = flush ? '1 : rdy[STAGES-1:0];
  assign out_valid   = v_q[STAGES-1];
  assign stage_valid = v_q;
  assign drain_done  = (state_q == ST_DONE);
  assign occupancy   = occ_q;
  assign txn_count   = txn_q;
  assign stall_count = stall_q;

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    occ_d   = '0;
    txn_d   = txn_q;
    stall_d = stall_q;

    if (flush) begin
      v_d = '0;
    end else begin
      if (rdy[0]) v_d[0] = in_valid & accept_en;
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) v_d[k] = v_q[k-1];
      end
    end

    unique case (state_q)
      ST_RUN:   if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN: if (v_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (flush) state_d = ST_RUN;

    for (int k = 0; k < STAGES; k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end

    if (in_valid && in_ready)    txn_d   = txn_q + CNT_W'(1);
    if (out_valid && !out_ready) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      v_q     <= '0;
      occ_q   <= '0;
      txn_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      occ_q   <= occ_d;
      txn_q   <= txn_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: doc/stitch_pipeline_ctrl.md
# stitch_pipeline_ctrl

Valid/ready sequencer for a stitched N-stage pipeline whose per-stage combinational modules are separated by `p<k>_*` pipeline registers. Generates per-register load enables from an input valid and an output ready, tracks per-stage occupancy, supports drain and flush, and counts accepted transactions and stall cycles. Sits beside the stitched wrapper; the wrapper's `always_ff` blocks use `stage_en[k]` as their load enable.

## Interface
- `STAGES`, default 2: number of pipeline register ranks (`p1`..`pSTAGES`); legal range 1..16.
- `CNT_W`, default 32: width of the transaction and stall counters.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: upstream has an operand for stage 0.
- `in_ready` output 1: operand accepted this cycle when `in_valid & in_ready`.
- `out_valid` output 1: final register `pSTAGES` holds a result.
- `out_ready` input 1: downstream consumes the result this cycle when `out_valid & out_ready`.
- `stage_en` output STAGES: bit k is the load enable of register `p(k+1)`.
- `stage_valid` output STAGES: bit k means `p(k+1)` holds a live result.
- `drain_req` input 1: one-cycle pulse; stop accepting and empty the pipe.
- `drain_done` output 1: one-cycle pulse once a drain completes.
- `flush` input 1: synchronous clear of all valid bits.
- `occupancy` output $clog2(STAGES+1): number of set `stage_valid` bits, registered.
- `txn_count` output CNT_W: number of accepted inputs, wraps modulo 2^CNT_W.
- `stall_count` output CNT_W: number of cycles with `out_valid & !out_ready`, wraps.

## Operation
- Ready chain, combinational: `r[STAGES] = out_ready`; `r[k] = !v[k] | r[k+1]`; `stage_en[k] = r[k]`.
- Valid update on an edge with `stage_en[k]`: `v[0] <= in_valid & accept_en`; `v[k] <= v[k-1]` for k>0. A register without enable holds.
- `in_ready = r[0] & accept_en`. `out_valid = v[STAGES-1]`. `stage_valid = v`.
- `accept_en` is 1 only in state RUN.
- FSM states and transitions:
  - RUN: the reset state. `drain_req` moves to DRAIN.
  - DRAIN: `in_ready = 0`. Bubbles still advance. Once `v == 0`, moves to DONE.
  - DONE: `drain_done = 1` for exactly this cycle, then moves to RUN.
- `drain_req` outside RUN is ignored. If the pipe is already empty when `drain_req` is seen, the sequence is RUN→DRAIN→DONE, so `drain_done` occurs 2 cycles after the request.
- `flush` has priority over all other update rules. On the edge with `flush=1`:
  - `v <= 0`; FSM goes to RUN.
  - Any in-progress drain is abandoned and no `drain_done` is produced.
  - `in_ready = 0` during the flush cycle; `stage_en` is all ones, so the wrapper loads don't-care data.
- `txn_count` increments on `in_valid & in_ready`. `stall_count` increments on `out_valid & !out_ready`. Neither counter is cleared by `flush`.
- `occupancy` is the popcount of the next-state `v`, registered, so it always equals popcount(`stage_valid`).

## Timing
- Reset values:
  - `v=0`, FSM=RUN, counters=0, `occupancy=0`, `drain_done=0`, `out_valid=0`.
  - `in_ready` follows `out_ready|!v` and is 1 out of reset.
- Latency: an input accepted at edge t gives `out_valid=1` after edge t+STAGES-1. With STAGES=2, an input accepted at cycle 0 gives `out_valid` in cycle 2 and the result is visible at `pSTAGES` after 2 edges.
- Throughput: 1 per cycle with `out_ready=1`. Bubbles collapse under backpressure, so the pipe holds STAGES entries before `in_ready` drops.
- Simultaneous input accept and output pop when full: both occur and occupancy is unchanged.
- Asynchronous reset mid-operation: all state clears immediately and in-flight data is discarded.

## Test plan
- Streaming, STAGES=2: `in_valid=1` for 5 cycles with `out_ready=1` → `out_valid` first high in cycle 2 and high for 5 cycles; `txn_count=5`; `stall_count=0`.
- Backpressure: hold `out_ready=0` and send 3 inputs → 2 accepted, `in_ready=0` from cycle 2, `occupancy=2`, `stall_count` increments each stalled cycle. Release `out_ready` → in-order drain.
- Bubble collapse: valid, gap, valid with `out_ready=0` → `stage_valid=2'b11` after 3 cycles.
- Drain: `drain_req` with 2 in flight and `out_ready=1` → `in_ready=0` immediately, `drain_done` pulses 1 cycle after `occupancy` reaches 0, then `in_ready` returns.
- Flush mid-drain: `flush` during DRAIN → `stage_valid=0` next cycle, no `drain_done`, FSM in RUN, counters retained.
- Async reset: `rst_n` low mid-stream → `out_valid`, `occupancy`, `txn_count` all 0 before the next clock edge.
